// File: rtl/key_load_ctrl.sv
// key_load_ctrl
//   Collects the unlock key for the locked c432 netlist as a byte stream over
//   a valid/ready handshake. The key is assembled in a shadow register.
//   keyinput is driven only once a complete load has been accepted; until then
//   it is held at zero, so the locked circuit stays corrupted.
//
//   Optional feature macro: KEY_LOAD_PARITY_EN
//     defined   - one trailing byte must equal the XOR of all key bytes.
//                 A mismatch raises error and blanks the key.
//     undefined - the load completes after NBYTES transfers; error is tied to 0.
//
// Ports
//   clk        : clock
//   rst_n      : synchronous active-low reset
//   start      : one-cycle pulse that begins a load, or restarts one
//   byte_in    : key byte from secure storage
//   byte_valid : byte_in is valid
//   byte_ready : a byte is accepted this cycle (decoded from state only)
//   keyinput   : key bus to the locked netlist; bit i drives keyinput_i
//   key_valid  : keyinput holds a complete, accepted key
//   busy       : a load is in progress
//   error      : the last load failed its parity check
module key_load_ctrl #(
    parameter int KEY_W = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [7:0]       byte_in,
    input  logic             byte_valid,
    output logic             byte_ready,
    output logic [KEY_W-1:0] keyinput,
    output logic             key_valid,
    output logic             busy,
    output logic             error
);

    localparam int NBYTES = KEY_W / 8;
    localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

`ifdef KEY_LOAD_PARITY_EN
    typedef enum logic [2:0] {IDLE, LOAD_KEY, LOAD_PAR, DONE, ERR} state_t;
`else
    typedef enum logic [1:0] {IDLE, LOAD_KEY, DONE} state_t;
`endif

    state_t                 state;
    logic [IDX_W-1:0]       cnt;
    logic [NBYTES-1:0][7:0] shadow;
    logic [NBYTES-1:0][7:0] shadow_nxt;
    logic                   last_byte;

`ifdef KEY_LOAD_PARITY_EN
    logic [7:0]             acc;
`else
    assign error = 1'b0;
`endif

    assign last_byte = (cnt == IDX_W'(NBYTES - 1));

    // Shadow contents including the byte being transferred this cycle.
    // Without parity, this lets the key go straight to keyinput on the
    // edge that accepts the last byte.
    always_comb begin
        shadow_nxt      = shadow;
        shadow_nxt[cnt] = byte_in;
    end

    // byte_ready and busy are registered alongside the state.
    // byte_ready is therefore a pure decode of state: 1 exactly in
    // LOAD_KEY/LOAD_PAR. Because of that, a transfer in those states is
    // just byte_valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            shadow     <= '0;
            byte_ready <= 1'b0;
            busy       <= 1'b0;
            key_valid  <= 1'b0;
            keyinput   <= '0;
`ifdef KEY_LOAD_PARITY_EN
            acc        <= '0;
            error      <= 1'b0;
`endif
        end else if (start) begin
            // start has priority in every state. It drops any published key.
            // It also discards a byte presented in the same cycle.
            state      <= LOAD_KEY;
            cnt        <= '0;
            shadow     <= '0;
            byte_ready <= 1'b1;
            busy       <= 1'b1;
            key_valid  <= 1'b0;
            keyinput   <= '0;
`ifdef KEY_LOAD_PARITY_EN
            acc        <= '0;
            error      <= 1'b0;
`endif
        end else begin
            case (state)
                LOAD_KEY: begin
                    if (byte_valid) begin
                        shadow <= shadow_nxt;
                        cnt    <= cnt + 1'b1;
`ifdef KEY_LOAD_PARITY_EN
                        acc    <= acc ^ byte_in;
                        if (last_byte) state <= LOAD_PAR;
`else
                        if (last_byte) begin
                            state      <= DONE;
                            byte_ready <= 1'b0;
                            busy       <= 1'b0;
                            key_valid  <= 1'b1;
                            keyinput   <= shadow_nxt;
                        end
`endif
                    end
                end
`ifdef KEY_LOAD_PARITY_EN
                LOAD_PAR: begin
                    if (byte_valid) begin
                        byte_ready <= 1'b0;
                        busy       <= 1'b0;
                        if (byte_in == acc) begin
                            state     <= DONE;
                            key_valid <= 1'b1;
                            keyinput  <= shadow;
                        end else begin
                            // Wipe the shadow so that no partial key persists.
                            state  <= ERR;
                            error  <= 1'b1;
                            shadow <= '0;
                        end
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_key_load_ctrl.sv
module tb_key_load_ctrl;

    localparam int KEY_W  = 64;
    localparam int NBYTES = KEY_W / 8;
`ifdef KEY_LOAD_PARITY_EN
    localparam int TOTAL  = NBYTES + 1;
`else
    localparam int TOTAL  = NBYTES;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [7:0]       byte_in;
    logic             byte_valid;
    logic             byte_ready;
    logic [KEY_W-1:0] keyinput;
    logic             key_valid;
    logic             busy;
    logic             error;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    key_load_ctrl #(.KEY_W(KEY_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .keyinput   (keyinput),
        .key_valid  (key_valid),
        .busy       (busy),
        .error      (error)
    );

    // Reference model. A load is "active" from start until TOTAL bytes
    // have been collected in a queue. The finished queue is then judged
    // as a whole.
    bit               m_active = 1'b0;
    bit               m_kv     = 1'b0;
    bit               m_err    = 1'b0;
    logic [KEY_W-1:0] m_key    = '0;
    logic [7:0]       q[$];
    logic [7:0]       m_x;
    logic [KEY_W-1:0] m_asm;
    bit               m_ok;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_active = 1'b0; m_kv = 1'b0; m_err = 1'b0; m_key = '0; q.delete();
        end else if (start) begin
            m_active = 1'b1; m_kv = 1'b0; m_err = 1'b0; m_key = '0; q.delete();
        end else if (m_active && byte_valid) begin
            q.push_back(byte_in);
            if (q.size() == TOTAL) begin
                m_x   = 8'h00;
                m_asm = '0;
                for (int i = 0; i < NBYTES; i++) begin
                    m_x = m_x ^ q[i];
                    m_asm[8*i +: 8] = q[i];
                end
`ifdef KEY_LOAD_PARITY_EN
                m_ok = (q[NBYTES] == m_x);
`else
                m_ok = 1'b1;
`endif
                m_active = 1'b0;
                m_kv     = m_ok;
                m_err    = !m_ok;
                m_key    = m_ok ? m_asm : '0;
            end
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (byte_ready !== m_active || busy !== m_active || key_valid !== m_kv ||
                error !== m_err || keyinput !== m_key) begin
                failures++;
                $display("FAIL cycle_cmp t=%0t got rdy=%b busy=%b kv=%b err=%b key=%h expected rdy=%b busy=%b kv=%b err=%b key=%h",
                         $time, byte_ready, busy, key_valid, error, keyinput,
                         m_active, m_active, m_kv, m_err, m_key);
            end
        end
    end

    task automatic chk(input string name, input logic [KEY_W-1:0] act, input logic [KEY_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input bit with_byte);
        start = 1'b1;
        if (with_byte) begin
            byte_valid = 1'b1;
            byte_in    = 8'hAA;
        end
        tick();
        start      = 1'b0;
        byte_valid = 1'b0;
    endtask

    // Presents one byte and holds it until it has been transferred.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        bit done = 1'b0;
        bit fire;
        int n    = 0;
        while (!done) begin
            byte_in    = b;
            byte_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            fire = byte_valid && byte_ready;
            @(posedge clk);
            #1;
            done = fire;
            n++;
            if (!done && n > 100) begin
                checks++;
                failures++;
                $display("FAIL send_timeout: got no ready in %0d cycles, expected ready", n);
                done = 1'b1;
            end
        end
        byte_valid = 1'b0;
    endtask

    task automatic send_key(input logic [KEY_W-1:0] k, input bit gaps, input bit bad_par);
        logic [7:0] x = 8'h00;
        for (int i = 0; i < NBYTES; i++) begin
            send_byte(k[8*i +: 8], gaps);
            x = x ^ k[8*i +: 8];
        end
`ifdef KEY_LOAD_PARITY_EN
        send_byte(bad_par ? (x ^ 8'h01) : x, gaps);
`else
        if (bad_par) x = 8'h00;
`endif
    endtask

    initial begin
        logic [KEY_W-1:0] k;
        rst_n = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;

        // Reset held for 3 edges.
        tick();
        chk_en = 1'b1;
        chk("rst_key", keyinput, '0);
        chk("rst_flags", {byte_ready, busy, key_valid, error}, '0);
        tick();
        tick();
        rst_n = 1'b1;
        byte_valid = 1'b1;   // must be ignored while idle
        tick();
        tick();
        byte_valid = 1'b0;
        chk("idle_ready", byte_ready, 1'b0);

        // Nominal load.
        pulse_start(1'b0);
        chk("start_ready", {byte_ready, busy}, 2'b11);
        send_key(64'h0123456789ABCDEF, 1'b0, 1'b0);
        chk("nom_key", keyinput, 64'h0123456789ABCDEF);
        chk("nom_kv_busy", {key_valid, busy}, 2'b10);
        tick();
        chk("nom_hold", keyinput, 64'h0123456789ABCDEF);

        // Parity failure.
        pulse_start(1'b0);
        chk("start_drop_key", {key_valid, keyinput}, '0);
        send_key(64'h0123456789ABCDEF, 1'b0, 1'b1);
`ifdef KEY_LOAD_PARITY_EN
        chk("par_err", {error, key_valid}, 2'b10);
        chk("par_key", keyinput, '0);
        pulse_start(1'b0);
        chk("par_err_clear", error, 1'b0);
`else
        chk("nopar_kv", key_valid, 1'b1);
        pulse_start(1'b0);
`endif

        // Backpressure with random gaps.
        k = {$urandom, $urandom};
        send_key(k, 1'b1, 1'b0);
        chk("gap_key", keyinput, k);

        // Restart mid-load; a byte presented alongside start is discarded.
        pulse_start(1'b0);
        for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1'b0);
        pulse_start(1'b1);
        send_key(64'hFFFFFFFF00000000, 1'b0, 1'b0);
        chk("restart_key", keyinput, 64'hFFFFFFFF00000000);
        chk("restart_kv", key_valid, 1'b1);

        // Reset mid-load.
        pulse_start(1'b0);
        for (int i = 0; i < 5; i++) send_byte(8'($urandom), 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rst_mid_all", {byte_ready, busy, key_valid, error, keyinput}, '0);
        byte_valid = 1'b1;
        tick();
        tick();
        byte_valid = 1'b0;
        chk("rst_mid_ready", byte_ready, 1'b0);

        // Randomized loads with noise, aborts and corrupt parity.
        for (int it = 0; it < 40; it++) begin
            int idle = $urandom_range(0, 3);
            for (int c = 0; c < idle; c++) begin
                byte_valid = 1'($urandom_range(0, 1));
                byte_in    = 8'($urandom);
                tick();
            end
            byte_valid = 1'b0;
            pulse_start(1'($urandom_range(0, 1)));
            if ($urandom_range(0, 4) == 0) begin
                int nb = $urandom_range(1, NBYTES - 1);
                for (int i = 0; i < nb; i++) send_byte(8'($urandom), 1'b1);
            end else begin
                k = {$urandom, $urandom};
                send_key(k, 1'b1, $urandom_range(0, 2) == 0);
            end
        end
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/key_load_ctrl.md
# key_load_ctrl

Sequential key-delivery stage that sits directly upstream of the CAS-Lock–protected c432 netlist. It accepts the 64-bit unlock key as a byte stream from on-chip secure storage over a valid/ready handshake and assembles it in a shadow register. It drives the locked circuit's `keyinput_0..keyinput_63` bus only after a complete, optionally parity-checked, load. Until then the bus is held at zero, so the locked output stays corrupted.

## Interface
- `KEY_W`, default 64: key width in bits. Must be a multiple of 8.
- `NBYTES`, derived as `KEY_W/8`: number of key bytes per load.

Ports:
- `clk` — in, 1: single clock.
- `rst_n` — in, 1: reset, **synchronous, active-low**.
- `start` — in, 1: single-cycle pulse that begins or restarts a key load.
- `byte_in` — in, 8: key byte from storage.
- `byte_valid` — in, 1: `byte_in` is valid.
- `byte_ready` — out, 1: block accepts a byte this cycle.
- `keyinput` — out, KEY_W: key bus to the locked netlist. Bit i drives `keyinput_i`.
- `key_valid` — out, 1: `keyinput` holds a complete, accepted key.
- `busy` — out, 1: a load is in progress.
- `error` — out, 1: last load failed its parity check. Constant 0 when parity is compiled out.

## Operation
- States: IDLE, LOAD_KEY, LOAD_PAR, DONE, ERR.
- **IDLE:**
  - `byte_ready=0`, `busy=0`.
  - `start` → LOAD_KEY: byte counter cleared, shadow cleared, running XOR cleared.
- **LOAD_KEY:**
  - `byte_ready=1`, `busy=1`.
  - On a transfer (`byte_valid & byte_ready`), byte k is written to `shadow[8k+7:8k]`, so byte 0 lands in the LSBs.
  - Each transfer increments the counter and XORs the byte into the parity accumulator.
  - When the transfer of byte NBYTES-1 completes:
    - with parity enabled → LOAD_PAR;
    - without parity → DONE.
- **LOAD_PAR** (parity builds only):
  - `byte_ready=1`.
  - On a transfer, compare `byte_in` with the accumulator: equal → DONE, unequal → ERR.
- **DONE:** `key_valid=1`; `keyinput=shadow`, held indefinitely.
- **ERR:**
  - `error=1`, `key_valid=0`, `keyinput=0`.
  - Shadow is cleared on entry, so no partial key persists.
- `start` in DONE or ERR:
  - → LOAD_KEY;
  - `key_valid`, `error` and `keyinput` drop to 0 on the next edge.
- `start` in LOAD_KEY or LOAD_PAR:
  - restarts the load: counter, shadow and accumulator cleared, state LOAD_KEY;
  - a byte presented in the same cycle is discarded.
- `byte_valid` with `byte_ready=0` is ignored. The sender holds `byte_in`/`byte_valid` until it sees ready.
- `keyinput` is never driven from a partially loaded shadow.

## Timing
- `rst_n=0` at a rising edge (including mid-load) forces:
  - state IDLE, counter 0, shadow 0, accumulator 0;
  - `keyinput=0`, `key_valid=0`, `busy=0`, `byte_ready=0`, `error=0`.
- `start` sampled at edge t: `byte_ready=1` and `busy=1` from cycle t+1.
- One byte is accepted per cycle at full rate. There are no bubbles between bytes.
- Last key byte accepted at edge t, no parity build: `key_valid=1`, `keyinput` valid and `busy=0` in cycle t+1.
- Parity byte accepted at edge t: `key_valid` or `error` asserted in cycle t+1. Minimum load length is NBYTES+1 transfers.
- All outputs are registered. There is no combinational path from inputs to `keyinput`.
- `byte_ready` is a function of state only.

## Configuration
- Macro: `KEY_LOAD_PARITY_EN`.
- **Defined:**
  - LOAD_PAR and ERR states exist;
  - an extra trailing byte equal to the XOR of all key bytes is required;
  - a mismatch raises `error` and blanks the key.
- **Undefined:**
  - LOAD_PAR and ERR are removed;
  - LOAD_KEY → DONE directly after NBYTES transfers;
  - `error` is tied to 0.

## Test plan
- **Reset:** hold `rst_n=0` 3 cycles, then release.
  - Required: all outputs 0, `byte_ready=0` until `start`.
- **Nominal load:** `start`, then bytes EF,CD,AB,89,67,45,23,01 back-to-back, then parity 00 (parity build).
  - Required: `keyinput=0x0123456789ABCDEF`, `key_valid=1` exactly one cycle after the last transfer, `busy=0`.
- **Parity fail:** same key bytes, parity byte 01.
  - Required: `error=1`, `key_valid=0`, `keyinput=0`.
  - A subsequent `start` clears `error` on the next cycle.
- **Backpressure/gaps:** `byte_valid` toggled randomly for 8 key bytes.
  - Required: only valid&ready cycles count; final key matches the sent bytes.
- **Restart mid-load:** `start` after 4 bytes, then a full 8-byte load of 0xFFFFFFFF00000000 (+ parity 00).
  - Required: `keyinput=0xFFFFFFFF00000000`, no residue from the first 4 bytes.
- **Reset mid-load:** `rst_n=0` for 1 cycle after 5 bytes.
  - Required: all outputs 0 next cycle; state IDLE; no `byte_ready` until `start`.
